mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: WLEN, default `WORD_LEN (32), data/address width.
REQ-002 Parameter: STARVE_LIMIT, default 4, maximum consecutive D grants while an I request waits.
REQ-003 The block SHALL have a single clock and an asynchronous active-low reset, with ports as follows:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_req  in  1  fetch request valid.
- i_addr  in  WLEN  fetch byte address.
- i_gnt  out  1  fetch request accepted this cycle.
- i_rvalid  out  1  fetch data valid.
- i_rdata  out  WLEN  fetched instruction.
- i_flush  in  1  discard any in-flight fetch response.
- d_req  in  1  data request valid.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  WLEN  data byte address.
- d_wdata  in  WLEN  store data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  load data valid, or error response.
- d_rdata  out  WLEN  load data.
- d_err  out  1  misaligned-access error, qualifies d_rvalid.
- mem_addr  out  WLEN  byte address to single-port synchronous RAM.
- mem_wen  out  1  RAM write enable.
- mem_wdata  out  WLEN  RAM write data.
- mem_rdata  in  WLEN  RAM read data, valid one cycle after address.

Function
REQ-004 The block SHALL issue at most one RAM access per cycle; mem_addr/mem_wen/mem_wdata are combinational from the granted request.
REQ-005 A grant SHALL be given the same cycle req is high; i_gnt and d_gnt are never high together.
REQ-006 Priority SHALL be D over I, unless the starvation counter equals STARVE_LIMIT and i_req is high, in which case I is granted.
REQ-007 Starvation counter (width clog2(STARVE_LIMIT+1)) SHALL increment on a D grant while i_req is high, saturate at STARVE_LIMIT, and clear on any I grant or any cycle with i_req low.
REQ-008 Load/fetch latency SHALL be one cycle: a request granted in cycle N yields its rvalid in cycle N+1, with rdata = mem_rdata.
REQ-009 A granted store SHALL assert mem_wen in the grant cycle, and SHALL produce no d_rvalid.
REQ-010 A D request with d_addr[1:0] != 0 SHALL be granted without RAM access (mem_wen=0), and SHALL produce d_rvalid=1, d_err=1, d_rdata=0 in N+1 for both loads and stores.
REQ-011 The response-tag register SHALL take states NONE, I, D_LD, D_ERR; it is loaded each cycle from the grant (NONE when there is no grant or the grant is a good store), and selects which rvalid fires next cycle.
REQ-012 If i_flush is high in cycle N, the I response due in cycle N SHALL be suppressed (i_rvalid=0), as SHALL the response of any fetch granted in cycle N.
REQ-013 When idle, mem_addr SHALL equal i_addr and mem_wen SHALL be 0; i_rdata and d_rdata SHALL be 0 when their rvalid is low.
REQ-014 Fetch addresses SHALL NOT be checked for alignment; i_addr is passed through unchanged.

Reset
REQ-015 On rst_n low, asynchronously: tag=NONE, starvation counter=0, all rvalid/d_err=0; combinational grants follow inputs but mem_wen SHALL be forced 0 while rst_n is low.
REQ-016 A response in flight at reset assertion SHALL be lost; there SHALL be no output pulse after reset release.

Verification
REQ-017 Set i_req=1, i_addr=0x10 alone -> i_gnt=1, mem_addr=0x10; next cycle i_rvalid=1, i_rdata=RAM[4].
REQ-018 Set i_req and d_req (load 0x20) in the same cycle -> d_gnt=1, i_gnt=0; next cycle d_rvalid=1, then I is granted.
REQ-019 Hold d_req for 6 cycles with i_req held, STARVE_LIMIT=4 -> 4 D grants, then 1 I grant, then D is granted again.
REQ-020 Store d_we=1, d_addr=0x8, d_wdata=0xDEADBEEF, then load 0x8 -> mem_wen pulses once; the load returns 0xDEADBEEF; the store gives no d_rvalid.
REQ-021 Load d_addr=0x6 -> mem_wen=0; next cycle d_rvalid=1, d_err=1, d_rdata=0.
REQ-022 Grant a fetch, then raise i_flush next cycle -> i_rvalid stays 0; drop rst_n mid-response -> all rvalid go 0 immediately.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the instruction/data requesters, the arbiter and the RAM.
// Handshake: a request is accepted in the cycle where req and gnt are both
// high; the response appears exactly one cycle later as a one-cycle rvalid
// pulse. There is no back-pressure on responses.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

interface mem_arbiter_if #(
  parameter int WLEN = `WORD_LEN
);
  logic            i_req;
  logic [WLEN-1:0] i_addr;
  logic            i_gnt;
  logic            i_rvalid;
  logic [WLEN-1:0] i_rdata;
  logic            i_flush;
  logic            d_req;
  logic            d_we;
  logic [WLEN-1:0] d_addr;
  logic [WLEN-1:0] d_wdata;
  logic            d_gnt;
  logic            d_rvalid;
  logic [WLEN-1:0] d_rdata;
  logic            d_err;
  logic [WLEN-1:0] mem_addr;
  logic            mem_wen;
  logic [WLEN-1:0] mem_wdata;
  logic [WLEN-1:0] mem_rdata;

  // Arbiter view: takes requests and RAM read data, drives grants,
  // responses and the RAM command.
  modport slave (
    input  i_req, i_addr, i_flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
    output mem_addr, mem_wen, mem_wdata
  );

  // Requester / RAM view.
  modport master (
    output i_req, i_addr, i_flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_addr, mem_wen, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of one single-port synchronous RAM.
// Data side wins by default; the fetch side is guaranteed a slot after
// STARVE_LIMIT consecutive data grants while it waits. Misaligned data
// accesses are answered with an error response without touching the RAM.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module mem_arbiter #(
  parameter int WLEN         = `WORD_LEN,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_arbiter_if.slave       bus,
  output logic [1:0]         dbg_tag
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  // Which response (if any) is due in the next cycle.
  typedef enum logic [1:0] {
    TAG_NONE  = 2'd0,
    TAG_I     = 2'd1,
    TAG_D_LD  = 2'd2,
    TAG_D_ERR = 2'd3
  } tag_e;

  tag_e          tag;
  logic [CW-1:0] starve;
  logic          grant_i;
  logic          grant_d;
  logic          d_misaligned;
  logic          d_access;

  // Grant selection: D over I unless I has waited through STARVE_LIMIT D grants.
  always_comb begin
    grant_i      = bus.i_req && (!bus.d_req || (starve == CW'(STARVE_LIMIT)));
    grant_d      = bus.d_req && !grant_i;
    d_misaligned = (bus.d_addr[1:0] != 2'b00);
    d_access     = grant_d && !d_misaligned;
  end

  // RAM command follows the winning request; idle and misaligned cycles
  // present the fetch address with no write.
  always_comb begin
    bus.mem_addr  = d_access ? bus.d_addr : bus.i_addr;
    bus.mem_wdata = bus.d_wdata;
    bus.mem_wen   = rst_n && d_access && bus.d_we;
    bus.i_gnt     = grant_i;
    bus.d_gnt     = grant_d;
  end

  // Response tag and starvation counter, both loaded from this cycle's grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag    <= TAG_NONE;
      starve <= '0;
    end else begin
      if (grant_i) begin
        tag <= bus.i_flush ? TAG_NONE : TAG_I;
      end else if (grant_d) begin
        if (d_misaligned)  tag <= TAG_D_ERR;
        else if (bus.d_we) tag <= TAG_NONE;
        else               tag <= TAG_D_LD;
      end else begin
        tag <= TAG_NONE;
      end

      if (!bus.i_req || grant_i) begin
        starve <= '0;
      end else if (grant_d && (starve != CW'(STARVE_LIMIT))) begin
        starve <= starve + 1'b1;
      end
    end
  end

  // Responses: a flush in the response cycle kills a pending fetch result;
  // read data is zeroed whenever its valid is low.
  always_comb begin
    bus.i_rvalid = (tag == TAG_I) && !bus.i_flush;
    bus.i_rdata  = bus.i_rvalid ? bus.mem_rdata : '0;
    bus.d_rvalid = (tag == TAG_D_LD) || (tag == TAG_D_ERR);
    bus.d_err    = (tag == TAG_D_ERR);
    bus.d_rdata  = (tag == TAG_D_LD) ? bus.mem_rdata : '0;
    dbg_tag      = tag;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic, compared against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int WLEN  = 32;
  localparam int LIMIT = 4;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_tag;

  mem_arbiter_if #(.WLEN(WLEN)) bus ();

  mem_arbiter #(.WLEN(WLEN), .STARVE_LIMIT(LIMIT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .dbg_tag (dbg_tag)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM behavioural model ----------------
  logic [WLEN-1:0] ram [64];

  function automatic logic [WLEN-1:0] init_val(input int i);
    return 32'h1357_0000 + (i * 32'h0001_0203) ^ 32'h00A5_5A00;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) ram[i] <= init_val(i);
    end else if (bus.mem_wen) begin
      ram[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end
    bus.mem_rdata <= ram[bus.mem_addr[7:2]];
  end

  // ---------------- reference model / scoreboard ----------------
  logic [WLEN-1:0] ref_mem [64];
  logic [WLEN-1:0] exp_q[$];
  int              kind_q[$];   // 1 = fetch, 2 = load, 3 = error
  int              waited;      // D grants given while I has been waiting
  int              n_checks;
  int              n_errors;

  task automatic check(input string tag, input logic [WLEN-1:0] got,
                       input logic [WLEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    kind_q.delete();
    waited = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive inputs, check responses due now and this cycle's
  // grant/RAM command, then record what the model expects next cycle.
  task automatic drive_cycle(input logic ireq, input logic [WLEN-1:0] iaddr,
                             input logic iflush, input logic dreq,
                             input logic dwe, input logic [WLEN-1:0] daddr,
                             input logic [WLEN-1:0] dwdata);
    int              kind;
    logic [WLEN-1:0] edata;
    logic            want_i, want_d, mis, wen;
    @(negedge clk);
    bus.i_req   = ireq;
    bus.i_addr  = iaddr;
    bus.i_flush = iflush;
    bus.d_req   = dreq;
    bus.d_we    = dwe;
    bus.d_addr  = daddr;
    bus.d_wdata = dwdata;
    #1;
    kind  = 0;
    edata = '0;
    if (kind_q.size() > 0) begin
      kind  = kind_q.pop_front();
      edata = exp_q.pop_front();
    end
    check("i_rvalid", WLEN'(bus.i_rvalid), WLEN'(kind == 1 && !iflush));
    check("i_rdata",  bus.i_rdata, (kind == 1 && !iflush) ? edata : '0);
    check("d_rvalid", WLEN'(bus.d_rvalid), WLEN'(kind >= 2));
    check("d_err",    WLEN'(bus.d_err), WLEN'(kind == 3));
    check("d_rdata",  bus.d_rdata, (kind == 2) ? edata : '0);

    want_i = ireq && (!dreq || waited == LIMIT);
    want_d = dreq && !want_i;
    mis    = (daddr[1:0] != 2'b00);
    wen    = want_d && dwe && !mis;
    check("i_gnt",    WLEN'(bus.i_gnt), WLEN'(want_i));
    check("d_gnt",    WLEN'(bus.d_gnt), WLEN'(want_d));
    check("mem_wen",  WLEN'(bus.mem_wen), WLEN'(wen));
    check("mem_addr", bus.mem_addr, (want_d && !mis) ? daddr : iaddr);
    if (wen) check("mem_wdata", bus.mem_wdata, dwdata);

    if (want_i) begin
      if (!iflush) begin
        kind_q.push_back(1);
        exp_q.push_back(ref_mem[iaddr[7:2]]);
      end
    end else if (want_d) begin
      if (mis) begin
        kind_q.push_back(3);
        exp_q.push_back('0);
      end else if (!dwe) begin
        kind_q.push_back(2);
        exp_q.push_back(ref_mem[daddr[7:2]]);
      end else begin
        ref_mem[daddr[7:2]] = dwdata;
      end
    end

    if (!ireq || want_i) waited = 0;
    else if (want_d && waited < LIMIT) waited++;
  endtask

  task automatic idle_cycle();
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    model_reset();
    rst_n       = 1'b0;
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.i_flush = 1'b0;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h8;
    bus.d_wdata = 32'h1234_5678;
    #3;
    // Reset state: store request visible as a grant but no RAM write.
    check("rst_mem_wen",  WLEN'(bus.mem_wen), '0);
    check("rst_d_gnt",    WLEN'(bus.d_gnt), 32'h1);
    check("rst_i_rvalid", WLEN'(bus.i_rvalid), '0);
    check("rst_d_rvalid", WLEN'(bus.d_rvalid), '0);
    check("rst_d_err",    WLEN'(bus.d_err), '0);
    check("rst_d_rdata",  bus.d_rdata, '0);
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Lone fetch of 0x10 returns word 4.
    drive_cycle(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle_cycle();
    // Simultaneous fetch and load: D first, then I.
    drive_cycle(1'b1, 32'h14, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
    drive_cycle(1'b1, 32'h14, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle_cycle();
    // Starvation: 4 D grants, one forced I grant, then D again.
    repeat (6) drive_cycle(1'b1, 32'h18, 1'b0, 1'b1, 1'b0, 32'h24, 32'h0);
    idle_cycle();
    // Store then load the same word.
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h8, 32'hDEAD_BEEF);
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h8, 32'h0);
    idle_cycle();
    // Misaligned load and misaligned store.
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h6, 32'h0);
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h3, 32'hFFFF_FFFF);
    idle_cycle();
    // Flush in the response cycle, then flush in the grant cycle.
    drive_cycle(1'b1, 32'h1C, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive_cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    drive_cycle(1'b1, 32'h21, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    idle_cycle();

    // Reset asserted while a fetch response is on the bus.
    drive_cycle(1'b1, 32'h30, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #2;
    bus.i_req = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("rstmid_i_rvalid", WLEN'(bus.i_rvalid), '0);
    check("rstmid_i_rdata",  bus.i_rdata, '0);
    check("rstmid_d_rvalid", WLEN'(bus.d_rvalid), '0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle();
    idle_cycle();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      logic            ireq, dreq, dwe, iflush;
      logic [WLEN-1:0] iaddr, daddr, wdata;
      ireq   = ($urandom_range(0, 3) != 0);
      dreq   = ($urandom_range(0, 2) != 0);
      dwe    = $urandom_range(0, 1) == 1;
      iflush = ($urandom_range(0, 7) == 0);
      iaddr  = WLEN'($urandom_range(0, 255));
      daddr  = WLEN'($urandom_range(0, 63) * 4);
      if ($urandom_range(0, 5) == 0) daddr = daddr | WLEN'($urandom_range(1, 3));
      wdata  = $urandom;
      drive_cycle(ireq, iaddr, iflush, dreq, dwe, daddr, wdata);
    end
    idle_cycle();
    idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
